// File: rtl/laser_pkg.sv
// Shared types for the laser-coverage front end: coordinates, frame points
// and the frame controller state encoding.
package laser_pkg;

   localparam int unsigned COORD_W    = 4;
   localparam int unsigned N_OBJ_DEF  = 40;
   localparam int unsigned WAIT_CNT_W = 16;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      coord_t y;
      coord_t x;
   } point_t;

   typedef enum logic [2:0] {
      FILL,
      KICK,
      STREAM,
      WAIT,
      HOLD
   } ctrl_state_t;

endpackage

// File: rtl/laser_obj_buf.sv
// Frame point store: one synchronous write port, one asynchronous read port,
// storage is not reset.
module laser_obj_buf
   import laser_pkg::*;
#(
   parameter  int unsigned N_OBJ = N_OBJ_DEF,
   localparam int unsigned AW    = $clog2(N_OBJ)
) (
   input  logic          CLK,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  point_t        wdata,
   input  logic [AW-1:0] raddr,
   output point_t        rdata
);

   point_t mem [N_OBJ];

   always_ff @(posedge CLK) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/laser_frame_ctrl.sv
// Frame controller: buffers a stalling point stream, replays it contiguously
// to the search core, captures the centres. Optional WAIT watchdog: LASER_FRAME_TIMEOUT_EN.
module laser_frame_ctrl
   import laser_pkg::*;
#(
   parameter int unsigned N_OBJ       = N_OBJ_DEF,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [COORD_W-1:0] in_x,
   input  logic [COORD_W-1:0] in_y,
   output logic               core_rst,
   output logic [COORD_W-1:0] core_x,
   output logic [COORD_W-1:0] core_y,
   input  logic               core_done,
   input  logic [COORD_W-1:0] core_c1x,
   input  logic [COORD_W-1:0] core_c1y,
   input  logic [COORD_W-1:0] core_c2x,
   input  logic [COORD_W-1:0] core_c2y,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [COORD_W-1:0] res_c1x,
   output logic [COORD_W-1:0] res_c1y,
   output logic [COORD_W-1:0] res_c2x,
   output logic [COORD_W-1:0] res_c2y,
   output logic               res_timeout,
   output logic               busy
);

   localparam int unsigned   AW   = $clog2(N_OBJ);
   localparam logic [AW-1:0] LAST = AW'(N_OBJ - 1);

   ctrl_state_t   state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic          buf_we;
   logic          cap_done;
   logic          cap_timeout;
   logic          wait_expired;
   point_t        wr_pt;
   point_t        rd_pt;

   assign wr_pt = '{y: in_y, x: in_x};

   // Read address is the point to present next cycle, so core_x/core_y can be registered.
   laser_obj_buf #(.N_OBJ(N_OBJ)) u_buf (
      .CLK   (CLK),
      .we    (buf_we),
      .waddr (wr_ptr_q),
      .wdata (wr_pt),
      .raddr (rd_ptr_d),
      .rdata (rd_pt)
   );

`ifdef LASER_FRAME_TIMEOUT_EN
   logic [WAIT_CNT_W-1:0] wait_cnt_q;

   // Zero outside WAIT, so it starts from 0 on every WAIT entry.
   always_ff @(posedge CLK) begin
      if (RST || state_q != WAIT) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_q + WAIT_CNT_W'(1);
      end
   end

   assign wait_expired = (wait_cnt_q == WAIT_CNT_W'(TIMEOUT_CYC - 1));
`else
   logic unused_timeout_cfg;

   assign wait_expired       = 1'b0;
   assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

   // Next-state and pointer logic.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      buf_we      = 1'b0;
      cap_done    = 1'b0;
      cap_timeout = 1'b0;
      case (state_q)
         FILL: begin
            if (in_valid && in_ready) begin
               buf_we = 1'b1;
               if (wr_ptr_q == LAST) begin
                  wr_ptr_d = '0;
                  state_d  = KICK;
               end else begin
                  wr_ptr_d = wr_ptr_q + AW'(1);
               end
            end
         end
         KICK: begin
            rd_ptr_d = '0;
            state_d  = STREAM;
         end
         STREAM: begin
            if (rd_ptr_q == LAST) begin
               rd_ptr_d = '0;
               state_d  = WAIT;
            end else begin
               rd_ptr_d = rd_ptr_q + AW'(1);
            end
         end
         WAIT: begin
            if (core_done) begin
               cap_done = 1'b1;
               state_d  = HOLD;
            end else if (wait_expired) begin
               cap_timeout = 1'b1;
               state_d     = HOLD;
            end
         end
         HOLD: begin
            if (res_valid && res_ready) begin
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // State and control outputs, all registered from the next state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= FILL;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         in_ready  <= 1'b0;
         core_rst  <= 1'b1;
         busy      <= 1'b0;
         res_valid <= 1'b0;
         core_x    <= '0;
         core_y    <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         in_ready  <= (state_d == FILL);
         core_rst  <= !(state_d == STREAM || state_d == WAIT);
         busy      <= (state_d != FILL);
         res_valid <= (state_d == HOLD);
         if (state_d == STREAM) begin
            {core_y, core_x} <= rd_pt;
         end else begin
            {core_y, core_x} <= '0;
         end
      end
   end

   // Result capture; values persist until the next capture.
   always_ff @(posedge CLK) begin
      if (RST) begin
         {res_c1x, res_c1y, res_c2x, res_c2y} <= '0;
         res_timeout                          <= 1'b0;
      end else if (cap_done) begin
         {res_c1x, res_c1y, res_c2x, res_c2y} <= {core_c1x, core_c1y, core_c2x, core_c2y};
         res_timeout                          <= 1'b0;
      end else if (cap_timeout) begin
         {res_c1x, res_c1y, res_c2x, res_c2y} <= '0;
         res_timeout                          <= 1'b1;
      end
   end

endmodule

// File: tb/tb_laser_frame_ctrl.sv
// Directed bench for laser_frame_ctrl: fill with/without stalls, contiguous
// replay, DONE capture, result hold, mid-stream reset, optional watchdog.
module tb_laser_frame_ctrl;
   import laser_pkg::*;

`ifdef LASER_FRAME_TIMEOUT_EN
   localparam int unsigned TO_CYC   = 64;
   localparam int          DONE_DLY = 20;
`else
   localparam int unsigned TO_CYC   = 4096;
   localparam int          DONE_DLY = 500;
`endif
   localparam int NP = 40;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_x = '0, in_y = '0;
   logic       core_rst;
   logic [3:0] core_x, core_y;
   logic       core_done = 1'b0;
   logic [3:0] core_c1x = '0, core_c1y = '0, core_c2x = '0, core_c2y = '0;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [3:0] res_c1x, res_c1y, res_c2x, res_c2y;
   logic       res_timeout;
   logic       busy;

   int n_vec  = 0;
   int n_miss = 0;

   laser_frame_ctrl #(.N_OBJ(NP), .TIMEOUT_CYC(TO_CYC)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_x        (in_x),
      .in_y        (in_y),
      .core_rst    (core_rst),
      .core_x      (core_x),
      .core_y      (core_y),
      .core_done   (core_done),
      .core_c1x    (core_c1x),
      .core_c1y    (core_c1y),
      .core_c2x    (core_c2x),
      .core_c2y    (core_c2y),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_c1x     (res_c1x),
      .res_c1y     (res_c1y),
      .res_c2x     (res_c2x),
      .res_c2y     (res_c2y),
      .res_timeout (res_timeout),
      .busy        (busy)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Frame point {y,x} for index i of a frame built with offset off.
   function automatic logic [7:0] pat(input int i, input int off);
      int v;
      v = i + off;
      return {4'(v >> 2), 4'(v)};
   endfunction

   function automatic logic [31:0] res_word();
      return 32'({res_valid, res_timeout, res_c1x, res_c1y, res_c2x, res_c2y});
   endfunction

   task automatic do_reset(input bit already);
      if (!already) begin
         @(negedge CLK);
         RST = 1'b1;
      end
      in_valid  = 1'b0;
      core_done = 1'b0;
      res_ready = 1'b0;
      @(negedge CLK);
      check_eq("rst_ctl", 32'({in_ready, core_rst, busy, res_valid}), 32'h4);
      check_eq("rst_core_pt", 32'({core_y, core_x}), 32'h0);
      check_eq("rst_res", res_word(), 32'h0);
      RST = 1'b0;
      @(negedge CLK);
      check_eq("rst_ready_after", 32'(in_ready), 32'h1);
   endtask

   task automatic fill_frame(input int off, input bit stall);
      int i     = 0;
      int guard = 0;
      while (i < NP) begin
         @(negedge CLK);
         in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         {in_y, in_x} = pat(i, off);
         if (in_valid && in_ready) i++;
         guard++;
         if (guard > 2000) begin
            check_eq("fill_budget", 32'(i), 32'(NP));
            break;
         end
      end
   endtask

   // Entered just after the last accepted point; leaves at WAIT cycle 0
   // (or with RST raised on the cycle presenting point stop_at).
   task automatic stream_check(input int off, input int stop_at);
      @(negedge CLK);
      in_valid = 1'b1;
      {in_y, in_x} = 8'hFF;
      core_done = 1'b1;
      {core_c1x, core_c1y, core_c2x, core_c2y} = 16'h7777;
      check_eq("kick_ctl", 32'({in_ready, core_rst, busy}), 32'h3);
      for (int k = 0; k < NP; k++) begin
         @(negedge CLK);
         check_eq($sformatf("stream_pt%0d", k), 32'({core_rst, core_y, core_x}),
                  32'({1'b0, pat(k, off)}));
         if (k == stop_at) begin
            RST = 1'b1;
            return;
         end
      end
      @(negedge CLK);
      core_done = 1'b0;
      in_valid  = 1'b0;
      check_eq("wait_pt", 32'({core_rst, core_y, core_x}), 32'h0);
      check_eq("wait_ctl", 32'({busy, res_valid, in_ready}), 32'h4);
   endtask

   task automatic release_res(input int hold, input logic [16:0] r);
      repeat (hold) begin
         @(negedge CLK);
         check_eq("hold_stable", res_word(), 32'({1'b1, r}));
      end
      res_ready = 1'b1;
      @(negedge CLK);
      res_ready = 1'b0;
      check_eq("after_hs_ctl", 32'({in_ready, busy, res_valid, core_rst}), 32'h9);
      check_eq("after_hs_res", res_word(), 32'({1'b0, r}));
   endtask

   task automatic done_and_hold(input int dly, input logic [15:0] c, input int hold);
      repeat (dly) @(negedge CLK);
      check_eq("wait_no_res", 32'(res_valid), 32'h0);
      core_done = 1'b1;
      {core_c1x, core_c1y, core_c2x, core_c2y} = c;
      @(negedge CLK);
      core_done = 1'b0;
      {core_c1x, core_c1y, core_c2x, core_c2y} = ~c;
      check_eq("res_first", res_word(), 32'({2'b10, c}));
      check_eq("hold_ctl", 32'({core_rst, in_ready, busy}), 32'h5);
      release_res(hold, {1'b0, c});
   endtask

   initial begin
      do_reset(1'b1);

      fill_frame(0, 1'b0);
      stream_check(0, NP);
      done_and_hold(DONE_DLY, 16'h34BC, 10);

      fill_frame(0, 1'b1);
      stream_check(0, NP);
      done_and_hold(3, 16'h12DE, 0);

      fill_frame(9, 1'b0);
      stream_check(9, 17);
      do_reset(1'b1);

      fill_frame(5, 1'b1);
      stream_check(5, NP);
      done_and_hold(0, 16'hA5F0, 2);

`ifdef LASER_FRAME_TIMEOUT_EN
      fill_frame(2, 1'b0);
      stream_check(2, NP);
      {core_c1x, core_c1y, core_c2x, core_c2y} = 16'h9999;
      repeat (TO_CYC - 1) @(negedge CLK);
      check_eq("to_not_yet", 32'(res_valid), 32'h0);
      @(negedge CLK);
      check_eq("to_res", res_word(), 32'h30000);
      release_res(1, 17'h10000);

      fill_frame(3, 1'b0);
      stream_check(3, NP);
      done_and_hold(int'(TO_CYC) - 1, 16'h5678, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got running, expected finished");
      $fatal(1);
   end

endmodule
